// File: rtl/truth_table_sweeper_if.sv
// Bus between a truth_table_sweeper and its controller/gate-unit side.
// Compare ports exist only when TTS_COMPARE_EN is defined.
interface truth_table_sweeper_if #(
  parameter int N_IN = 2
);
  localparam int TW = 2 ** N_IN;

  logic            start;
  logic            busy;
  logic            done;
  logic [N_IN-1:0] dut_in;
  logic            dut_s;
  logic [TW-1:0]   table_out;
`ifdef TTS_COMPARE_EN
  logic [TW-1:0]   expected;
  logic            pass;
  logic [N_IN-1:0] mismatch_idx;
`endif

  // Controller and gate unit: issues start, returns the unit output.
  modport master (
    output start,
    output dut_s,
    input  busy,
    input  done,
    input  dut_in,
    input  table_out
`ifdef TTS_COMPARE_EN
    ,
    output expected,
    input  pass,
    input  mismatch_idx
`endif
  );

  // Sweeper side.
  modport slave (
    input  start,
    input  dut_s,
    output busy,
    output done,
    output dut_in,
    output table_out
`ifdef TTS_COMPARE_EN
    ,
    input  expected,
    output pass,
    output mismatch_idx
`endif
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Steps every input combination into a combinational gate unit, samples its output
// after SETTLE cycles and builds a truth-table word. Optional checker: TTS_COMPARE_EN.
module truth_table_sweeper #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  truth_table_sweeper_if.slave bus
);
  localparam int              TW          = 2 ** N_IN;
  localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [N_IN-1:0] IDX_LAST    = N_IN'(TW - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_APPLY   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [N_IN-1:0] index_q, index_d;
  logic [3:0]      settle_q, settle_d;
  logic [TW-1:0]   table_q, table_d;

`ifdef TTS_COMPARE_EN
  logic [TW-1:0]   expected_q, expected_d;
  logic            pass_q, pass_d;
  logic [N_IN-1:0] mismatch_q, mismatch_d;

  // Lowest set bit position of v, or 0 when v is all zeros.
  function automatic logic [N_IN-1:0] lowest_set(input logic [TW-1:0] v);
    logic [N_IN-1:0] r;
    r = {N_IN{1'b0}};
    for (int i = TW - 1; i >= 0; i--) begin
      if (v[i]) begin
        r = N_IN'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction
`endif

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      index_q    <= {N_IN{1'b0}};
      settle_q   <= 4'd0;
      table_q    <= {TW{1'b0}};
`ifdef TTS_COMPARE_EN
      expected_q <= {TW{1'b0}};
      pass_q     <= 1'b0;
      mismatch_q <= {N_IN{1'b0}};
`endif
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      settle_q   <= settle_d;
      table_q    <= table_d;
`ifdef TTS_COMPARE_EN
      expected_q <= expected_d;
      pass_q     <= pass_d;
      mismatch_q <= mismatch_d;
`endif
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_APPLY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_APPLY: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = ST_CAPTURE;
        end else begin
          state_d = ST_APPLY;
        end
      end
      ST_CAPTURE: begin
        if (index_q == IDX_LAST) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_APPLY;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Index, settle counter and table updates; a new sweep starts from a clean table.
  always_comb begin
    index_d  = index_q;
    settle_d = settle_q;
    table_d  = table_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          index_d  = {N_IN{1'b0}};
          settle_d = 4'd0;
          table_d  = {TW{1'b0}};
        end else begin
          index_d  = index_q;
        end
      end
      ST_APPLY: settle_d = settle_q + 4'd1;
      ST_CAPTURE: begin
        settle_d         = 4'd0;
        table_d[index_q] = bus.dut_s;
        if (index_q != IDX_LAST) begin
          index_d = index_q + {{(N_IN-1){1'b0}}, 1'b1};
        end else begin
          index_d = index_q;
        end
      end
      ST_DONE: index_d = index_q;
      default: index_d = index_q;
    endcase
  end

`ifdef TTS_COMPARE_EN
  // Verdict is formed on the final capture edge so it is valid in the DONE cycle.
  always_comb begin
    expected_d = expected_q;
    pass_d     = pass_q;
    mismatch_d = mismatch_q;
    if ((state_q == ST_IDLE) && bus.start) begin
      expected_d = bus.expected;
      pass_d     = 1'b0;
      mismatch_d = {N_IN{1'b0}};
    end else if ((state_q == ST_CAPTURE) && (index_q == IDX_LAST)) begin
      pass_d     = (table_d == expected_q);
      mismatch_d = lowest_set(table_d ^ expected_q);
    end else begin
      pass_d     = pass_q;
    end
  end

  assign bus.pass         = pass_q;
  assign bus.mismatch_idx = mismatch_q;
`endif

  // Outputs decoded from the state register only.
  always_comb begin
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    bus.dut_in = {N_IN{1'b0}};
    case (state_q)
      ST_IDLE: bus.busy = 1'b0;
      ST_APPLY, ST_CAPTURE: begin
        bus.busy   = 1'b1;
        bus.dut_in = index_q;
      end
      ST_DONE: bus.done = 1'b1;
      default: bus.busy = 1'b0;
    endcase
  end

  assign bus.table_out = table_q;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Table-driven bench for truth_table_sweeper: three instances (N_IN/SETTLE variants)
// driven by behavioural gate units, plus hand sequences for held start and mid-sweep reset.
module tb_truth_table_sweeper;
  localparam int G_ANDN = 0;
  localparam int G_OR   = 1;
  localparam int G_XOR3 = 2;

  logic clk = 1'b0;
  logic reset;
  logic start_r [3];
  int   gsel [3];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  truth_table_sweeper_if #(.N_IN(2)) if0 ();
  truth_table_sweeper_if #(.N_IN(2)) if1 ();
  truth_table_sweeper_if #(.N_IN(3)) if2 ();

  truth_table_sweeper #(.N_IN(2), .SETTLE(1)) u0 (.clk(clk), .reset(reset), .bus(if0.slave));
  truth_table_sweeper #(.N_IN(2), .SETTLE(3)) u1 (.clk(clk), .reset(reset), .bus(if1.slave));
  truth_table_sweeper #(.N_IN(3), .SETTLE(1)) u2 (.clk(clk), .reset(reset), .bus(if2.slave));

  // Behavioural gate units: a = MSB of dut_in, b = LSB.
  function automatic logic gate_f(input int g, input logic [2:0] v);
    case (g)
      G_ANDN:  return v[1] & ~v[0];
      G_OR:    return v[1] | v[0];
      G_XOR3:  return v[2] ^ v[1] ^ v[0];
      default: return 1'b0;
    endcase
  endfunction

  assign if0.start = start_r[0];
  assign if1.start = start_r[1];
  assign if2.start = start_r[2];
  assign if0.dut_s = gate_f(gsel[0], {1'b0, if0.dut_in});
  assign if1.dut_s = gate_f(gsel[1], {1'b0, if1.dut_in});
  assign if2.dut_s = gate_f(gsel[2], if2.dut_in);

  logic       done_w [3];
  logic       busy_w [3];
  logic [7:0] tbl_w  [3];
  logic [2:0] din_w  [3];
  assign done_w[0] = if0.done;
  assign done_w[1] = if1.done;
  assign done_w[2] = if2.done;
  assign busy_w[0] = if0.busy;
  assign busy_w[1] = if1.busy;
  assign busy_w[2] = if2.busy;
  assign tbl_w[0]  = {4'b0000, if0.table_out};
  assign tbl_w[1]  = {4'b0000, if1.table_out};
  assign tbl_w[2]  = if2.table_out;
  assign din_w[0]  = {1'b0, if0.dut_in};
  assign din_w[1]  = {1'b0, if1.dut_in};
  assign din_w[2]  = if2.dut_in;

`ifdef TTS_COMPARE_EN
  logic [3:0] exp0;
  assign if0.expected = exp0;
  assign if1.expected = 4'b0000;
  assign if2.expected = 8'h00;
`endif

  typedef struct {
    int         u;
    int         gate;
    int         settle;
    logic [7:0] tbl;
    int         lat;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One start pulse, then follow the sweep to its DONE cycle and one cycle after.
  task automatic run_sweep(input int u, input int settle, input logic [7:0] exp_tbl,
                           input int exp_lat);
    int cyc;
    @(negedge clk);
    start_r[u] = 1'b1;
    @(negedge clk);
    start_r[u] = 1'b0;
    cyc = 1;
    check("table_cleared_on_start", tbl_w[u], 32'd0);
    while (!done_w[u] && cyc < 200) begin
      check("busy_in_sweep", busy_w[u], 32'd1);
      check("dut_in_step", din_w[u], (cyc - 1) / (settle + 1));
      @(negedge clk);
      cyc++;
    end
    check("done_seen", done_w[u], 32'd1);
    check("done_latency", cyc, exp_lat);
    check("busy_in_done", busy_w[u], 32'd0);
    check("dut_in_in_done", din_w[u], 32'd0);
    check("table_final", tbl_w[u], exp_tbl);
    @(negedge clk);
    check("done_one_cycle", done_w[u], 32'd0);
    check("idle_busy", busy_w[u], 32'd0);
    check("table_held", tbl_w[u], exp_tbl);
  endtask

  initial begin
    int cyc;
    vecs[0] = '{u: 0, gate: G_ANDN, settle: 1, tbl: 8'b0000_0100, lat: 9};
    vecs[1] = '{u: 1, gate: G_ANDN, settle: 3, tbl: 8'b0000_0100, lat: 17};
    vecs[2] = '{u: 0, gate: G_OR,   settle: 1, tbl: 8'b0000_1110, lat: 9};
    vecs[3] = '{u: 2, gate: G_XOR3, settle: 1, tbl: 8'b1001_0110, lat: 17};
    vecs[4] = '{u: 1, gate: G_OR,   settle: 3, tbl: 8'b0000_1110, lat: 17};

    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_r[i] = 1'b0;
      gsel[i]    = G_ANDN;
    end
`ifdef TTS_COMPARE_EN
    exp0 = 4'b0000;
`endif
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_busy", busy_w[i], 32'd0);
      check("rst_done", done_w[i], 32'd0);
      check("rst_dut_in", din_w[i], 32'd0);
      check("rst_table", tbl_w[i], 32'd0);
    end
    reset = 1'b0;

    for (int v = 0; v < 5; v++) begin
      gsel[vecs[v].u] = vecs[v].gate;
      run_sweep(vecs[v].u, vecs[v].settle, vecs[v].tbl, vecs[v].lat);
    end

    // start held high: sweeps end at +9 and +19 with one IDLE cycle between.
    gsel[0] = G_OR;
    @(negedge clk);
    start_r[0] = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      check("held_busy", busy_w[0], ((c % 10 == 9) || (c % 10 == 0)) ? 32'd0 : 32'd1);
      check("held_done", done_w[0], (c % 10 == 9) ? 32'd1 : 32'd0);
      if (c % 10 == 9) begin
        check("held_table", tbl_w[0], 32'h0E);
      end else begin
        cyc = c;
      end
    end
    start_r[0] = 1'b0;
    cyc = 25;
    while (!done_w[0] && cyc < 80) begin
      @(negedge clk);
      cyc++;
    end
    check("held_third_latency", cyc, 32'd29);
    @(negedge clk);

    // Reset during the third APPLY cycle discards the partial table.
    gsel[0] = G_OR;
    start_r[0] = 1'b1;
    @(negedge clk);
    start_r[0] = 1'b0;
    repeat (4) @(negedge clk);
    check("partial_table", tbl_w[0], 32'h02);
    check("partial_dut_in", din_w[0], 32'd2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", busy_w[0], 32'd0);
    check("midrst_done", done_w[0], 32'd0);
    check("midrst_dut_in", din_w[0], 32'd0);
    check("midrst_table", tbl_w[0], 32'd0);
    @(negedge clk);
    check("midrst_stays_idle", busy_w[0], 32'd0);
    run_sweep(0, 1, 8'h0E, 9);

`ifdef TTS_COMPARE_EN
    gsel[0] = G_ANDN;
    exp0 = 4'b0100;
    run_sweep(0, 1, 8'h04, 9);
    check("cmp_pass_match", if0.pass, 32'd1);
    check("cmp_idx_match", if0.mismatch_idx, 32'd0);
    exp0 = 4'b0110;
    run_sweep(0, 1, 8'h04, 9);
    check("cmp_pass_miss", if0.pass, 32'd0);
    check("cmp_idx_miss", if0.mismatch_idx, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
